// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port among
// NUM_REQ requesters in the w_clk domain. One owner at a time, bursts of at most
// MAX_BURST words, stalls while f_full is high.
// Optional macro WR_ARB_WATERMARK_EN adds wptr/rptr_gray_sync inputs and an
// afull output; while afull is high no new burst is started.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from prio_q
// BURST | cur_owner granted while !f_full; ends on last, cap or abandon
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = 8
) (
    input  logic                           w_clk,
    input  logic                           wrst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_in,
    input  logic                           f_full,
`ifdef WR_ARB_WATERMARK_EN
    input  logic [ADDR_WIDTH:0]            wptr,
    input  logic [ADDR_WIDTH:0]            rptr_gray_sync,
    output logic                           afull,
`endif
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           w_en,
    output logic [DATA_WIDTH-1:0]          wdata,
    output logic [$clog2(NUM_REQ)-1:0]     cur_owner,
    output logic                           busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   prio_q, prio_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] din [NUM_REQ];
    logic [OW-1:0]   pick_idx;
    logic [OW-1:0]   cand;
    logic            pick_vld;
    logic            transfer;
    logic            start_ok;
    logic [OW-1:0]   owner_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_din
        assign din[g] = wdata_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef WR_ARB_WATERMARK_EN
    logic                afull_q, afull_d;
    logic [ADDR_WIDTH:0] rptr_bin;
    logic [ADDR_WIDTH:0] level;

    // Gray-to-binary on the synced read pointer, then compare free space to a full burst
    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rptr_bin[i] = ^(rptr_gray_sync >> i);
        end
        level   = wptr - rptr_bin;
        afull_d = (((1 << ADDR_WIDTH) - int'(level)) < MAX_BURST);
    end

    // Watermark flag register
    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) afull_q <= 1'b0;
        else       afull_q <= afull_d;
    end

    assign afull    = afull_q;
    assign start_ok = ~afull_q;
`else
    assign start_ok = 1'b1;
`endif

    // Round-robin search: walk downward so the lowest offset from prio_q wins
    always_comb begin
        pick_idx = prio_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = OW'((int'(prio_q) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Grant, write strobe and data mux for the current owner
    always_comb begin
        gnt      = '0;
        busy     = (state_q == BURST);
        transfer = busy & req[owner_q] & ~f_full;
        if (busy) gnt[owner_q] = ~f_full;
        w_en     = transfer;
        wdata    = transfer ? din[owner_q] : '0;
    end

    assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign cur_owner = owner_q;

    // Next-state logic: start, count, and end bursts
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && start_ok) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    prio_d  = owner_inc;
                end else if (transfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last[owner_q] || cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        prio_d  = owner_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and arbitration registers
    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
